// File: rtl/huffman_tree_builder.sv
// huffman_tree_builder: turns a stream of per-symbol code lengths into the
// flattened binary tree table read by huffman_decoder. Canonical codes follow
// the deflate construction. Each node's child pair sits at {node, bit}. A value
// below NUMCODES is a leaf symbol. A value of NUMCODES or more points to child
// node (value - NUMCODES). All ones marks an empty entry.
// Optional feature: define HUFF_BUILD_CHECK_EN to flag over-subscribed codes
// on oerr and suppress the colliding write.
module huffman_tree_builder #(
    parameter int unsigned NUMCODES = 288,
    parameter int unsigned OUTWIDTH = 10,
    localparam int unsigned AW = $clog2(2 * NUMCODES)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                istart,
    input  logic                ien,
    input  logic [3:0]          ilen,
    input  logic                ilast,
    output logic                obusy,
    output logic                odone,
    output logic                oerr,
    output logic                wen,
    output logic [AW-1:0]       waddr,
    output logic [OUTWIDTH-1:0] wdata,
    output logic [AW-1:0]       raddr,
    input  logic [OUTWIDTH-1:0] rdata
);

    localparam int unsigned CW = $clog2(NUMCODES + 1);
    localparam int unsigned NW = AW - 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_NEXT, S_CLEAR, S_SCAN, S_READ, S_CHECK, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       n_q, n_d;
    logic [CW-1:0]       s_q, s_d;
    logic [AW-1:0]       k_q, k_d;
    logic [15:0]         code_q, code_d;
    logic [15:0]         c_q, c_d;
    logic [3:0]          len_q, len_d;
    logic [3:0]          i_q, i_d;
    logic [NW-1:0]       node_q, node_d;
    logic [NW-1:0]       filled_q, filled_d;
    logic                obusy_q, obusy_d;
    logic                odone_q, odone_d;
    logic                oerr_q, oerr_d;
    logic                wen_q, wen_d;
    logic [AW-1:0]       waddr_q, waddr_d;
    logic [OUTWIDTH-1:0] wdata_q, wdata_d;

    logic [3:0]          lens_q [NUMCODES];
    logic [CW-1:0]       bl_count_q [16];
    logic [15:0]         next_code_q [16];

    logic                bl_clr, load_we, nc_we, nc_inc;
    logic                do_leaf, do_new, do_follow, adv;

    logic [3:0]          b_idx;
    logic [CW-1:0]       bc_prev;
    logic [3:0]          bit_idx;
    logic                cur_bit;
    logic [AW-1:0]       cur_addr;
    logic [3:0]          s_len;
    logic                last_sym;
    logic                rd_empty, rd_ptr, at_last;
    logic [NW-1:0]       new_node;

    assign b_idx    = k_q[3:0];
    assign bc_prev  = (b_idx == 4'd1) ? '0 : bl_count_q[4'(b_idx - 4'd1)];
    assign bit_idx  = 4'(len_q - 4'd1 - i_q);
    assign cur_bit  = c_q[bit_idx];
    assign cur_addr = {node_q, cur_bit};
    assign s_len    = lens_q[s_q];
    assign last_sym = ((s_q + CW'(1)) == n_q);
    assign rd_empty = (rdata == '1);
    assign rd_ptr   = (rdata >= OUTWIDTH'(NUMCODES));
    assign at_last  = (i_q == 4'(len_q - 4'd1));
    assign new_node = filled_q + NW'(1);

    // Read address comes straight from the walk registers while in READ
    assign raddr = (state_q == S_READ) ? cur_addr : '0;

    assign obusy = obusy_q;
    assign odone = odone_q;
    assign oerr  = oerr_q;
    assign wen   = wen_q;
    assign waddr = waddr_q;
    assign wdata = wdata_q;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state, datapath and output decode
    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        s_d       = s_q;
        k_d       = k_q;
        code_d    = code_q;
        c_d       = c_q;
        len_d     = len_q;
        i_d       = i_q;
        node_d    = node_q;
        filled_d  = filled_q;
        obusy_d   = obusy_q;
        odone_d   = 1'b0;
        oerr_d    = oerr_q;
        wen_d     = 1'b0;
        waddr_d   = '0;
        wdata_d   = '0;
        bl_clr    = 1'b0;
        load_we   = 1'b0;
        nc_we     = 1'b0;
        nc_inc    = 1'b0;
        do_leaf   = 1'b0;
        do_new    = 1'b0;
        do_follow = 1'b0;
        adv       = 1'b0;

        case (state_q)
            S_IDLE: ;
            S_LOAD: begin
                if (ien) begin
                    if (n_q < CW'(NUMCODES)) begin
                        load_we = 1'b1;
                        n_d     = n_q + CW'(1);
                    end
                    if (ilast) begin
                        state_d = S_NEXT;
                        k_d     = AW'(1);
                        code_d  = '0;
                    end
                end
            end
            S_NEXT: begin
                code_d = (code_q + 16'(bc_prev)) << 1;
                nc_we  = 1'b1;
                if (k_q == AW'(15)) begin
                    state_d = S_CLEAR;
                    k_d     = '0;
                end else begin
                    k_d = k_q + AW'(1);
                end
            end
            S_CLEAR: begin
                wen_d    = 1'b1;
                waddr_d  = k_q;
                wdata_d  = '1;
                filled_d = '0;
                s_d      = '0;
                if (k_q == AW'(2 * NUMCODES - 1)) begin
                    state_d = (n_q == '0) ? S_DONE : S_SCAN;
                end else begin
                    k_d = k_q + AW'(1);
                end
            end
            S_SCAN: begin
                if (s_len == 4'd0) begin
                    adv = 1'b1;
                end else begin
                    len_d   = s_len;
                    c_d     = next_code_q[s_len];
                    nc_inc  = 1'b1;
                    node_d  = '0;
                    i_d     = '0;
                    state_d = S_READ;
                end
            end
            S_READ: state_d = S_CHECK;
            S_CHECK: begin
`ifdef HUFF_BUILD_CHECK_EN
                if (rd_empty && at_last)       do_leaf   = 1'b1;
                else if (rd_empty)             do_new    = 1'b1;
                else if (rd_ptr && !at_last)   do_follow = 1'b1;
                else begin
                    oerr_d = 1'b1;
                    adv    = 1'b1;
                end
`else
                if (at_last)                   do_leaf   = 1'b1;
                else if (rd_ptr && !rd_empty)  do_follow = 1'b1;
                else                           do_new    = 1'b1;
`endif
                if (do_leaf) begin
                    wen_d   = 1'b1;
                    waddr_d = cur_addr;
                    wdata_d = OUTWIDTH'(s_q);
                    adv     = 1'b1;
                end
                if (do_new) begin
                    wen_d    = 1'b1;
                    waddr_d  = cur_addr;
                    wdata_d  = OUTWIDTH'(new_node) + OUTWIDTH'(NUMCODES);
                    filled_d = new_node;
                    node_d   = new_node;
                    i_d      = i_q + 4'd1;
                    state_d  = S_READ;
                end
                if (do_follow) begin
                    node_d  = NW'(rdata - OUTWIDTH'(NUMCODES));
                    i_d     = i_q + 4'd1;
                    state_d = S_READ;
                end
            end
            S_DONE: begin
                odone_d = 1'b1;
                obusy_d = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Step to the next symbol or finish
        if (adv) begin
            if (last_sym) begin
                state_d = S_DONE;
            end else begin
                s_d     = s_q + CW'(1);
                state_d = S_SCAN;
            end
        end

        // A new stream aborts whatever is in flight, with no write this cycle
        if (istart) begin
            state_d = S_LOAD;
            n_d     = '0;
            code_d  = '0;
            oerr_d  = 1'b0;
            obusy_d = 1'b1;
            odone_d = 1'b0;
            wen_d   = 1'b0;
            waddr_d = '0;
            wdata_d = '0;
            bl_clr  = 1'b1;
            load_we = 1'b0;
            nc_we   = 1'b0;
            nc_inc  = 1'b0;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            n_q      <= '0;
            s_q      <= '0;
            k_q      <= '0;
            code_q   <= '0;
            c_q      <= '0;
            len_q    <= '0;
            i_q      <= '0;
            node_q   <= '0;
            filled_q <= '0;
            obusy_q  <= 1'b0;
            odone_q  <= 1'b0;
            oerr_q   <= 1'b0;
            wen_q    <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            n_q      <= n_d;
            s_q      <= s_d;
            k_q      <= k_d;
            code_q   <= code_d;
            c_q      <= c_d;
            len_q    <= len_d;
            i_q      <= i_d;
            node_q   <= node_d;
            filled_q <= filled_d;
            obusy_q  <= obusy_d;
            odone_q  <= odone_d;
            oerr_q   <= oerr_d;
            wen_q    <= wen_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
        end
    end

    // Length store, length histogram and per-length next code
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int j = 0; j < int'(NUMCODES); j++) lens_q[j] <= '0;
            for (int j = 0; j < 16; j++) begin
                bl_count_q[j]  <= '0;
                next_code_q[j] <= '0;
            end
        end else begin
            if (bl_clr) begin
                for (int j = 0; j < 16; j++) bl_count_q[j] <= '0;
            end
            if (load_we) begin
                lens_q[n_q]      <= ilen;
                bl_count_q[ilen] <= bl_count_q[ilen] + CW'(1);
            end
            if (nc_we)  next_code_q[b_idx] <= code_d;
            if (nc_inc) next_code_q[s_len] <= next_code_q[s_len] + 16'd1;
        end
    end

endmodule

// File: tb/tb_huffman_tree_builder.sv
// Bench for huffman_tree_builder: RAM model, canonical-code tree reference,
// directed vectors, random valid length sets and abort/reset sequences.
module tb_huffman_tree_builder;

    localparam int NUMC  = 288;
    localparam int OW    = 10;
    localparam int AW    = 10;
    localparam int TBL   = 2 * NUMC;
    localparam int EMPTY = 1023;
`ifdef HUFF_BUILD_CHECK_EN
    localparam int COLL_SYM0 = 0;
    localparam int COLL_ERR  = 1;
`else
    localparam int COLL_SYM0 = 2;
    localparam int COLL_ERR  = 0;
`endif

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          istart = 1'b0;
    logic          ien = 1'b0;
    logic [3:0]    ilen = 4'd0;
    logic          ilast = 1'b0;
    logic          obusy, odone, oerr, wen;
    logic [AW-1:0] waddr, raddr;
    logic [OW-1:0] wdata, rdata;

    huffman_tree_builder #(.NUMCODES(NUMC), .OUTWIDTH(OW)) dut (
        .clk(clk), .rstn(rstn), .istart(istart), .ien(ien), .ilen(ilen),
        .ilast(ilast), .obusy(obusy), .odone(odone), .oerr(oerr), .wen(wen),
        .waddr(waddr), .wdata(wdata), .raddr(raddr), .rdata(rdata)
    );

    always #5 clk = ~clk;

    // Tree RAM: one write port, one read port with one cycle of latency
    logic [OW-1:0] mem [1024];
    always @(posedge clk) begin
        if (wen) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

    int tests_run = 0;
    int fails = 0;
    int lens_tb [NUMC];
    int exp_tab [TBL];

    typedef struct {
        int          n;
        logic [31:0] l;
        logic [59:0] e;
        int          err;
        bit          use_model;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Canonical codes by walking lengths in increasing order, then a prefix map
    // assigns node ids in the order symbols first need them.
    task automatic model_build(input int n);
        int code_of [NUMC];
        int node_of [int];
        int c, filled, L, pk, ck, bt, parent;
        c = 0;
        for (int len = 1; len <= 15; len++) begin
            for (int s = 0; s < n; s++) begin
                if (lens_tb[s] == len) begin
                    code_of[s] = c;
                    c++;
                end
            end
            c = c << 1;
        end
        for (int a = 0; a < TBL; a++) exp_tab[a] = EMPTY;
        node_of[1] = 0;
        filled = 0;
        for (int s = 0; s < n; s++) begin
            L = lens_tb[s];
            if (L == 0) continue;
            c = code_of[s];
            for (int d = 0; d < L; d++) begin
                pk     = (1 << d) | (c >> (L - d));
                bt     = (c >> (L - 1 - d)) & 1;
                parent = node_of[pk];
                if (d == L - 1) begin
                    exp_tab[2 * parent + bt] = s;
                end else begin
                    ck = (1 << (d + 1)) | (c >> (L - 1 - d));
                    if (!node_of.exists(ck)) begin
                        filled++;
                        node_of[ck] = filled;
                        exp_tab[2 * parent + bt] = NUMC + filled;
                    end
                end
            end
        end
    endtask

    function automatic int exp_lat(input int n);
        int sum = 0;
        for (int i = 0; i < n; i++) sum += lens_tb[i];
        return 15 + TBL + n + 2 * sum + 1;
    endfunction

    task automatic send_lens(input int n);
        @(posedge clk); #1 istart = 1'b1;
        @(posedge clk); #1 istart = 1'b0;
        for (int i = 0; i < n; i++) begin
            ien   = 1'b1;
            ilen  = 4'(lens_tb[i]);
            ilast = (i == n - 1);
            @(posedge clk); #1;
        end
        ien = 1'b0; ilast = 1'b0; ilen = 4'd0;
    endtask

    task automatic run_build(input int n, output int lat, output int err, output int busy);
        send_lens(n);
        lat = 0;
        while (odone !== 1'b1 && lat < 20000) begin
            @(posedge clk); #1;
            lat++;
        end
        err  = int'(oerr);
        busy = int'(obusy);
    endtask

    task automatic check_table(input string name);
        int bad = 0;
        int first = -1;
        for (int a = 0; a < TBL; a++) begin
            if (int'(mem[a]) != exp_tab[a]) begin
                bad++;
                if (first < 0) first = a;
            end
        end
        tests_run++;
        if (bad != 0) begin
            fails++;
            $display("FAIL %s: %0d entries differ, addr %0d got %0d expected %0d",
                     name, bad, first, mem[first], exp_tab[first]);
        end
    endtask

    // Follow a bit string (MSB first) from the root; -1 if no leaf at the end
    function automatic int walk(input int bits, input int nb);
        int node = 0;
        int v, bt;
        for (int k = nb - 1; k >= 0; k--) begin
            bt = (bits >> k) & 1;
            v  = int'(mem[2 * node + bt]);
            if (v < NUMC) return (k == 0) ? v : -1;
            node = v - NUMC;
        end
        return -1;
    endfunction

    initial begin
        vec_t vecs [5];
        int   lat, err, busy, n, budget, l, wcount;

        vecs[0] = '{4, 32'h0000_3312,
                    {10'd3, 10'd2, 10'd290, 10'd0, 10'd289, 10'd1}, 0, 1'b1};
        vecs[1] = '{3, 32'h0000_0111,
                    {10'd1023, 10'd1023, 10'd1023, 10'd1023, 10'd1, 10'(COLL_SYM0)},
                    COLL_ERR, 1'b0};
        vecs[2] = '{3, 32'h0000_0221,
                    {10'd1023, 10'd1023, 10'd2, 10'd1, 10'd289, 10'd0}, 0, 1'b1};
        vecs[3] = '{8, 32'h3333_3333,
                    {10'd1, 10'd0, 10'd291, 10'd290, 10'd292, 10'd289}, 0, 1'b1};
        vecs[4] = '{5, 32'h0002_1020,
                    {10'd1023, 10'd1023, 10'd4, 10'd1, 10'd289, 10'd3}, 0, 1'b1};

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_obusy", int'(obusy), 0);
        chk("rst_odone", int'(odone), 0);
        chk("rst_oerr",  int'(oerr),  0);
        chk("rst_wen",   int'(wen),   0);
        chk("rst_waddr", int'(waddr), 0);
        chk("rst_wdata", int'(wdata), 0);
        chk("rst_raddr", int'(raddr), 0);
        rstn = 1'b1;

        // Directed vectors
        for (int v = 0; v < 5; v++) begin
            n = vecs[v].n;
            for (int i = 0; i < n; i++) lens_tb[i] = int'(vecs[v].l[4*i +: 4]);
            run_build(n, lat, err, busy);
            chk($sformatf("vec%0d_latency", v), lat, exp_lat(n));
            chk($sformatf("vec%0d_oerr", v), err, vecs[v].err);
            chk($sformatf("vec%0d_obusy", v), busy, 0);
            for (int j = 0; j < 6; j++)
                chk($sformatf("vec%0d_tab%0d", v, j), int'(mem[j]), int'(vecs[v].e[10*j +: 10]));
            if (vecs[v].use_model) begin
                model_build(n);
                check_table($sformatf("vec%0d_table", v));
            end
        end

        // Random prefix-free length sets
        for (int t = 0; t < 12; t++) begin
            n = $urandom_range(2, 40);
            budget = 32768;
            for (int i = 0; i < n; i++) begin
                l = $urandom_range(0, 10);
                if (l > 0 && (1 << (15 - l)) <= budget) budget -= (1 << (15 - l));
                else l = 0;
                lens_tb[i] = l;
            end
            model_build(n);
            run_build(n, lat, err, busy);
            chk($sformatf("rnd%0d_latency", t), lat, exp_lat(n));
            chk($sformatf("rnd%0d_oerr", t), err, 0);
            check_table($sformatf("rnd%0d_table", t));
        end

        // Fixed literal/length alphabet
        for (int i = 0; i < NUMC; i++)
            lens_tb[i] = (i < 144) ? 8 : (i < 256) ? 9 : (i < 280) ? 7 : 8;
        model_build(NUMC);
        run_build(NUMC, lat, err, busy);
        chk("fixed_latency", lat, 5664);
        chk("fixed_oerr", err, 0);
        check_table("fixed_table");
        chk("fixed_dec_0000000", walk(0, 7), 256);
        chk("fixed_dec_00110000", walk('h30, 8), 0);
        chk("fixed_dec_110010000", walk('h190, 9), 144);

        // Abort in the middle of CLEAR, then rebuild with {1,1}
        lens_tb[0] = 2; lens_tb[1] = 1; lens_tb[2] = 3; lens_tb[3] = 3;
        send_lens(4);
        wcount = 0;
        while (wen !== 1'b1 && wcount < 100) begin
            @(posedge clk); #1;
            wcount++;
        end
        chk("abort_clear_started", int'(wen), 1);
        repeat (100) begin @(posedge clk); #1; end
        lens_tb[0] = 1; lens_tb[1] = 1;
        model_build(2);
        run_build(2, lat, err, busy);
        chk("abort_latency", lat, exp_lat(2));
        chk("abort_oerr", err, 0);
        chk("abort_tab0", int'(mem[0]), 0);
        chk("abort_tab1", int'(mem[1]), 1);
        check_table("abort_table");

        // All-zero lengths: empty table
        for (int i = 0; i < NUMC; i++) lens_tb[i] = 0;
        model_build(NUMC);
        run_build(NUMC, lat, err, busy);
        chk("zero_latency", lat, 15 + 576 + 288 + 1);
        check_table("zero_table");

        // Reset while a READ is in progress
        lens_tb[0] = 2; lens_tb[1] = 1; lens_tb[2] = 3; lens_tb[3] = 3;
        send_lens(4);
        wcount = 0;
        while (raddr == '0 && wcount < 2000) begin
            @(posedge clk); #1;
            wcount++;
        end
        chk("rstread_in_read", int'(raddr), 1);
        chk("rstread_busy_before", int'(obusy), 1);
        rstn = 1'b0;
        #1;
        chk("rstread_outputs", int'({obusy, odone, oerr, wen, waddr, wdata, raddr}), 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        wcount = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (wen || obusy) wcount++;
        end
        chk("rstread_idle_quiet", wcount, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
